// File: rtl/i2c_master_arbiter_if.sv
// rtl/i2c_master_arbiter_if.sv - command/handshake bus between the arbiter and the I2C Master core
interface i2c_master_arbiter_if;
    logic       M_start;
    logic       M_r_w;
    logic       M_set_pointer;
    logic [6:0] M_adr;
    logic [7:0] M_pointer;
    logic [7:0] M_data_in;
    logic [7:0] M_data_in2;
    logic       M_ready;
    logic       M_error;
    logic       M_data_valid;
    logic [7:0] M_data_out;

    modport master (
        output M_start, M_r_w, M_set_pointer, M_adr, M_pointer, M_data_in, M_data_in2,
        input  M_ready, M_error, M_data_valid, M_data_out
    );

    modport slave (
        input  M_start, M_r_w, M_set_pointer, M_adr, M_pointer, M_data_in, M_data_in2,
        output M_ready, M_error, M_data_valid, M_data_out
    );
endinterface

// File: rtl/i2c_master_arbiter.sv
// rtl/i2c_master_arbiter.sv - round-robin arbiter and retry/timeout sequencer in front of one I2C Master
module i2c_master_arbiter #(
    parameter int N_REQ       = 2,
    parameter int MAX_RETRY   = 2,
    parameter int TIMEOUT_CYC = 4095,
    parameter int GAP_CYC     = 15
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [N_REQ-1:0]     Req,
    input  logic [N_REQ-1:0]     Req_rw,
    input  logic [N_REQ-1:0]     Req_set_pointer,
    input  logic [7*N_REQ-1:0]   Req_adr,
    input  logic [8*N_REQ-1:0]   Req_pointer,
    input  logic [8*N_REQ-1:0]   Req_data,
    input  logic [8*N_REQ-1:0]   Req_data2,
    output logic [N_REQ-1:0]     Gnt,
    output logic [N_REQ-1:0]     Done,
    output logic                 Fail,
    output logic [7:0]           Rd_data,
    output logic                 Busy,
    i2c_master_arbiter_if.master m
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYC - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_CYC - 1);
    localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);

    typedef enum logic [2:0] {S_IDLE, S_LATCH, S_START_WAIT, S_BUSY, S_GAP, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d, last_q, last_d;
    logic [N_REQ-1:0] gnt_q, gnt_d, done_q, done_d;
    logic             fail_q, fail_d, err_q, err_d, dv_q, dv_d;
    logic [7:0]       rd_data_q, rd_data_d, cap_q, cap_d, retry_q, retry_d;
    logic [15:0]      tmo_q, tmo_d, gap_q, gap_d;
    logic             start_q, start_d, rw_q, rw_d, sp_q, sp_d;
    logic [6:0]       adr_q, adr_d;
    logic [7:0]       ptr_q, ptr_d, din_q, din_d, din2_q, din2_d;

    logic             pick_found, err_now;
    logic [N_REQ-1:0] pick_oh;
    logic [IW-1:0]    pick_idx;
    logic             pick_rw, pick_sp;
    logic [6:0]       pick_adr;
    logic [7:0]       pick_ptr, pick_din, pick_din2;
    int               start_i;

    // Search starts one past the last granted requester, wrapping once around.
    always_comb begin
        pick_found = 1'b0;
        pick_oh    = '0;
        pick_idx   = '0;
        pick_rw    = 1'b0;
        pick_sp    = 1'b0;
        pick_adr   = '0;
        pick_ptr   = '0;
        pick_din   = '0;
        pick_din2  = '0;
        start_i    = (int'(last_q) + 1) % N_REQ;
        for (int i = 0; i < N_REQ; i++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (!pick_found && Req[j] && (j == (start_i + i) % N_REQ)) begin
                    pick_found = 1'b1;
                    pick_oh[j] = 1'b1;
                    pick_idx   = IW'(j);
                    pick_rw    = Req_rw[j];
                    pick_sp    = Req_set_pointer[j];
                    pick_adr   = Req_adr[j*7 +: 7];
                    pick_ptr   = Req_pointer[j*8 +: 8];
                    pick_din   = Req_data[j*8 +: 8];
                    pick_din2  = Req_data2[j*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        fail_d    = 1'b0;
        err_d     = err_q;
        dv_d      = m.M_data_valid;
        rd_data_d = rd_data_q;
        cap_d     = cap_q;
        retry_d   = retry_q;
        tmo_d     = tmo_q;
        gap_d     = gap_q;
        start_d   = start_q;
        rw_d      = rw_q;
        sp_d      = sp_q;
        adr_d     = adr_q;
        ptr_d     = ptr_q;
        din_d     = din_q;
        din2_d    = din2_q;
        err_now   = err_q | m.M_error;

        case (state_q)
            S_IDLE: begin
                if (pick_found && m.M_ready) begin
                    state_d = S_LATCH;
                    gnt_d   = pick_oh;
                    idx_d   = pick_idx;
                    rw_d    = pick_rw;
                    sp_d    = pick_sp;
                    adr_d   = pick_adr;
                    ptr_d   = pick_ptr;
                    din_d   = pick_din;
                    din2_d  = pick_din2;
                    err_d   = 1'b0;
                    retry_d = '0;
                    tmo_d   = '0;
                end
            end
            S_LATCH: begin
                state_d = S_START_WAIT;
                start_d = 1'b1;
                tmo_d   = '0;
            end
            S_START_WAIT: begin
                if (!m.M_ready) begin
                    state_d = S_BUSY;
                    start_d = 1'b0;
                    tmo_d   = '0;
                end else if (tmo_q >= TMO_LAST) begin
                    state_d = S_DONE;
                    start_d = 1'b0;
                    done_d  = gnt_q;
                    fail_d  = 1'b1;
                end else begin
                    tmo_d = (tmo_q == 16'hFFFF) ? tmo_q : tmo_q + 16'd1;
                end
            end
            S_BUSY: begin
                if (rw_q && m.M_data_valid && !dv_q)
                    cap_d = m.M_data_out;
                err_d = err_now;
                if (m.M_ready) begin
                    if (err_now && (retry_q < RETRY_MAX)) begin
                        state_d = S_GAP;
                        retry_d = retry_q + 8'd1;
                        err_d   = 1'b0;
                        gap_d   = '0;
                    end else begin
                        state_d = S_DONE;
                        done_d  = gnt_q;
                        fail_d  = err_now;
                        if (rw_q)
                            rd_data_d = cap_d;
                    end
                end else if (tmo_q >= TMO_LAST) begin
                    state_d = S_DONE;
                    done_d  = gnt_q;
                    fail_d  = 1'b1;
                    if (rw_q)
                        rd_data_d = cap_d;
                end else begin
                    tmo_d = (tmo_q == 16'hFFFF) ? tmo_q : tmo_q + 16'd1;
                end
            end
            S_GAP: begin
                if (gap_q >= GAP_LAST) begin
                    state_d = S_START_WAIT;
                    start_d = 1'b1;
                    tmo_d   = '0;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                last_d  = idx_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            last_q    <= IW'(N_REQ - 1);
            gnt_q     <= '0;
            done_q    <= '0;
            fail_q    <= 1'b0;
            err_q     <= 1'b0;
            dv_q      <= 1'b0;
            rd_data_q <= '0;
            cap_q     <= '0;
            retry_q   <= '0;
            tmo_q     <= '0;
            gap_q     <= '0;
            start_q   <= 1'b0;
            rw_q      <= 1'b0;
            sp_q      <= 1'b0;
            adr_q     <= '0;
            ptr_q     <= '0;
            din_q     <= '0;
            din2_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            fail_q    <= fail_d;
            err_q     <= err_d;
            dv_q      <= dv_d;
            rd_data_q <= rd_data_d;
            cap_q     <= cap_d;
            retry_q   <= retry_d;
            tmo_q     <= tmo_d;
            gap_q     <= gap_d;
            start_q   <= start_d;
            rw_q      <= rw_d;
            sp_q      <= sp_d;
            adr_q     <= adr_d;
            ptr_q     <= ptr_d;
            din_q     <= din_d;
            din2_q    <= din2_d;
        end
    end

    assign Gnt             = gnt_q;
    assign Done            = done_q;
    assign Fail            = fail_q;
    assign Rd_data         = rd_data_q;
    assign Busy            = (state_q != S_IDLE);
    assign m.M_start       = start_q;
    assign m.M_r_w         = rw_q;
    assign m.M_set_pointer = sp_q;
    assign m.M_adr         = adr_q;
    assign m.M_pointer     = ptr_q;
    assign m.M_data_in     = din_q;
    assign m.M_data_in2    = din2_q;
endmodule

// File: tb/tb_i2c_master_arbiter.sv
// tb/tb_i2c_master_arbiter.sv - directed self-checking bench for i2c_master_arbiter
module tb_i2c_master_arbiter;
    localparam int N_REQ = 2;
    localparam int GAP   = 15;

    logic             Clk = 1'b0;
    logic             Rst;
    logic [1:0]       Req, Req_rw, Req_set_pointer;
    logic [13:0]      Req_adr;
    logic [15:0]      Req_pointer, Req_data, Req_data2;
    logic [1:0]       Gnt, Done;
    logic             Fail, Busy;
    logic [7:0]       Rd_data;

    int n_cmp = 0;
    int n_err = 0;
    int start_total = 0;
    logic start_prev = 1'b0;
    logic gnt_bad = 1'b0;
    int base, waited;
    logic [63:0] fields_latch;

    i2c_master_arbiter_if mif();

    i2c_master_arbiter #(.N_REQ(N_REQ), .MAX_RETRY(2), .TIMEOUT_CYC(100), .GAP_CYC(GAP)) dut (
        .Clk(Clk), .Rst(Rst), .Req(Req), .Req_rw(Req_rw), .Req_set_pointer(Req_set_pointer),
        .Req_adr(Req_adr), .Req_pointer(Req_pointer), .Req_data(Req_data), .Req_data2(Req_data2),
        .Gnt(Gnt), .Done(Done), .Fail(Fail), .Rd_data(Rd_data), .Busy(Busy), .m(mif.master)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (mif.M_start && !start_prev) start_total++;
        start_prev <= mif.M_start;
        if (Gnt == 2'b11) gnt_bad <= 1'b1;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mfields();
        return {31'd0, mif.M_r_w, mif.M_set_pointer, mif.M_adr, mif.M_pointer, mif.M_data_in, mif.M_data_in2};
    endfunction

    // One Master transfer: wait for Start, drop Ready, pulse Data_valid (optionally with Error), raise Ready.
    task automatic master_attempt(input logic with_err, input logic [7:0] d, output int w);
        w = 0;
        while (mif.M_start !== 1'b1 && w < 100) begin
            tick();
            w++;
        end
        if (w >= 100) chk("start_wait_bound", 64'd0, 64'd1);
        mif.M_ready = 1'b0;
        tick();
        mif.M_data_valid = 1'b1;
        mif.M_data_out   = d;
        mif.M_error      = with_err;
        tick();
        mif.M_data_valid = 1'b0;
        mif.M_error      = 1'b0;
        tick();
        mif.M_ready = 1'b1;
        tick();
    endtask

    initial begin
        Rst = 1'b1;
        Req = '0; Req_rw = '0; Req_set_pointer = '0;
        Req_adr = '0; Req_pointer = '0; Req_data = '0; Req_data2 = '0;
        mif.M_ready = 1'b1; mif.M_error = 1'b0; mif.M_data_valid = 1'b0; mif.M_data_out = '0;
        tick(); tick();
        chk("reset_outputs", {Gnt, Done, Fail, Rd_data, Busy, mif.M_start}, 64'd0);

        // single read from requester 0
        Rst = 1'b0;
        Req = 2'b01; Req_rw = 2'b01; Req_adr[6:0] = 7'h48; Req_pointer[7:0] = 8'h00;
        tick();
        chk("read_gnt", Gnt, 2'b01);
        chk("read_adr_rw", {mif.M_adr, mif.M_r_w}, {7'h48, 1'b1});
        chk("read_busy", Busy, 1'b1);
        tick();
        chk("read_start", mif.M_start, 1'b1);
        tick();
        chk("read_start_held", mif.M_start, 1'b1);
        master_attempt(1'b0, 8'hA5, waited);
        chk("read_done", {Done, Fail}, {2'b01, 1'b0});
        chk("read_data", Rd_data, 8'hA5);
        Req = 2'b00;
        tick();
        chk("read_after", {Done, Gnt, Busy, Rd_data}, {2'b00, 2'b00, 1'b0, 8'hA5});

        // write with set_pointer from requester 1
        Req = 2'b10; Req_rw = 2'b00; Req_set_pointer = 2'b10;
        Req_adr[13:7] = 7'h50; Req_pointer[15:8] = 8'h12; Req_data[15:8] = 8'h3C; Req_data2[15:8] = 8'hC3;
        tick();
        chk("write_gnt", Gnt, 2'b10);
        fields_latch = mfields();
        chk("write_fields", fields_latch, {31'd0, 1'b0, 1'b1, 7'h50, 8'h12, 8'h3C, 8'hC3});
        master_attempt(1'b0, 8'h77, waited);
        chk("write_done", {Done, Fail}, {2'b10, 1'b0});
        chk("write_fields_stable", mfields(), fields_latch);
        chk("write_rd_unchanged", Rd_data, 8'hA5);
        Req = 2'b00;
        tick();

        // round robin with both requesting continuously
        Req = 2'b11; Req_rw = 2'b11;
        for (int k = 0; k < 4; k++) begin
            if (k == 0) tick();
            else begin
                tick();
                chk("rr_gap_idle", Gnt, 2'b00);
                tick();
            end
            chk("rr_gnt", Gnt, (k % 2 == 1) ? 2'b10 : 2'b01);
            master_attempt(1'b0, 8'h10 + 8'(k), waited);
            chk("rr_done", {Done, Rd_data}, {((k % 2 == 1) ? 2'b10 : 2'b01), 8'h10 + 8'(k)});
        end
        Req = 2'b00;
        tick();
        chk("rr_never_both", gnt_bad, 1'b0);

        // two errors then success: three Start pulses
        base = start_total;
        Req = 2'b01; Req_rw = 2'b01;
        tick();
        master_attempt(1'b1, 8'h01, waited);
        chk("retry1_no_done", Done, 2'b00);
        master_attempt(1'b1, 8'h02, waited);
        chk("retry_gap_len", 64'(waited >= GAP), 64'd1);
        master_attempt(1'b0, 8'h5A, waited);
        chk("retry_ok_done", {Done, Fail, Rd_data}, {2'b01, 1'b0, 8'h5A});
        chk("retry_ok_starts", start_total - base, 3);
        Req = 2'b00;
        tick();

        // errors on every attempt: Fail after three Start pulses
        base = start_total;
        Req = 2'b01;
        tick();
        master_attempt(1'b1, 8'h03, waited);
        master_attempt(1'b1, 8'h04, waited);
        master_attempt(1'b1, 8'h05, waited);
        chk("retry_fail_done", {Done, Fail}, {2'b01, 1'b1});
        Req = 2'b00;
        repeat (20) tick();
        chk("retry_fail_starts", start_total - base, 3);

        // timeout: Ready never returns
        Req = 2'b01;
        tick();
        tick();
        mif.M_ready = 1'b0;
        tick();
        waited = 0;
        while (Done === 2'b00 && waited < 300) begin
            tick();
            waited++;
        end
        chk("timeout_cycles", waited, 100);
        chk("timeout_done", {Done, Fail}, {2'b01, 1'b1});
        Req = 2'b00;
        tick();
        chk("timeout_idle", Busy, 1'b0);
        mif.M_ready = 1'b1;

        // reset while BUSY
        Req = 2'b10;
        tick();
        tick();
        mif.M_ready = 1'b0;
        tick();
        tick();
        Rst = 1'b1;
        tick();
        chk("midreset_outputs", {Gnt, Done, Fail, Rd_data, Busy, mif.M_start}, 64'd0);
        Rst = 1'b0; mif.M_ready = 1'b1; Req = 2'b11;
        tick();
        chk("midreset_first_gnt", Gnt, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/i2c_master_arbiter.md
Name: i2c_master_arbiter

Overview:
Arbiter and transaction sequencer in front of the I2C Master. Shares one Master between N_REQ requesters with round-robin grant. Latches the winning request's fields, drives the Master command inputs, and handshakes on Ready, Data_valid and Error. Retries failed transfers, applies a watchdog timeout, and returns read data and status to the requester.

Parameters:
N_REQ, 2, number of requesters (2..8)
MAX_RETRY, 2, re-issues allowed after Master Error (0 = none)
TIMEOUT_CYC, 4095, Clk cycles allowed in START_WAIT or BUSY before abort (max 65535)
GAP_CYC, 15, idle Clk cycles between an error and the retry (min 1)

Ports:
Clk  in  1  system clock, the same clock fed to the Master's Clk_in
Rst  in  1  synchronous active-high reset
Req  in  N_REQ  request per requester; held until that requester's Done
Req_rw  in  N_REQ  per-requester R_W (1 = read)
Req_set_pointer  in  N_REQ  per-requester Set_pointer
Req_adr  in  7*N_REQ  per-requester 7-bit slave address, requester i at [7i+6:7i]
Req_pointer  in  8*N_REQ  per-requester pointer byte
Req_data  in  8*N_REQ  per-requester first write byte
Req_data2  in  8*N_REQ  per-requester second write byte
Gnt  out  N_REQ  one-hot grant
Done  out  N_REQ  one-cycle completion pulse to the granted requester
Fail  out  1  valid with Done; 1 = Error after retries, or timeout
Rd_data  out  8  read byte, valid with Done; held until the next Done
Busy  out  1  1 whenever state is not IDLE
M_start  out  1  to Master Start
M_r_w, M_set_pointer  out  1 each  to Master
M_adr  out  7  to Master Adr
M_pointer, M_data_in, M_data_in2  out  8 each  to Master Pointer, Data_in, Data_in2
M_ready, M_error, M_data_valid  in  1 each  from Master
M_data_out  in  8  from Master Data_out

Behaviour:
- Reset (synchronous, Rst=1 at a Clk edge):
  - state=IDLE
  - all outputs 0; Rd_data=0
  - retry counter and timeout counter 0
  - round-robin pointer set so requester 0 has highest priority
  - reset mid-transaction drops M_start at once and does not pulse Done.
- States: IDLE, LATCH, START_WAIT, BUSY, GAP, DONE.
- IDLE:
  - if any Req bit is set and M_ready=1, pick the first requester at or after (last_granted+1) mod N_REQ.
  - next: LATCH.
  - if M_ready=0, wait in IDLE.
- LATCH (1 cycle):
  - Gnt[idx]=1.
  - register idx and all of that requester's fields onto the M_* outputs.
  - clear err flag, retry count, timeout count.
  - M_* outputs stay constant from LATCH to the end of DONE.
- START_WAIT:
  - M_start=1 until M_ready=0, then go to BUSY with M_start=0.
  - if timeout count reaches TIMEOUT_CYC: go to DONE with err=1, timeout=1.
- BUSY:
  - read (M_r_w=1): on rising edge of M_data_valid, capture M_data_out into an internal buffer.
  - if M_error=1 on any cycle, set err=1.
  - when M_ready returns to 1:
    - if err=1 and retry < MAX_RETRY: retry+1, clear err, go to GAP.
    - otherwise go to DONE.
  - timeout count reaching TIMEOUT_CYC: go to DONE with Fail=1.
- GAP: count GAP_CYC cycles with M_start=0, then return to START_WAIT. Timeout count restarts at each START_WAIT entry.
- DONE (1 cycle):
  - Done[idx]=1; Fail=err or timeout.
  - Rd_data = captured byte on a read; unchanged on a write.
  - last_granted=idx. Gnt deasserts next cycle. Next state: IDLE.
- Requester drops Req mid-transaction: no abort; Done still pulses.
- Back-to-back: the earliest next Gnt is 2 cycles after Done (IDLE, then LATCH).
- Simultaneous requests: only one grant at a time; Gnt is always one-hot or zero.
- Timeout counter is 16 bits and saturates; it never wraps.

Test Plan:
- Single read: Req[0]=1, Req_adr[0]=7'h48, Req_rw[0]=1, Req_pointer[0]=8'h00. Master returns 8'hA5 → Gnt[0] one cycle after Req, M_start held until M_ready falls, Done[0] pulse, Fail=0, Rd_data=8'hA5.
- Round-robin: Req=2'b11 held continuously → grants in order 0,1,0,1. Each Done precedes the next Gnt by 2 cycles; Gnt never 2'b11.
- Error retry: Master asserts Error on the first 2 attempts, succeeds on the 3rd (MAX_RETRY=2) → 3 M_start pulses, each retry ≥GAP_CYC cycles after Ready, Fail=0. With errors on all 3 attempts → Fail=1, exactly 3 M_start pulses.
- Timeout: M_ready held 0 after Start, TIMEOUT_CYC=100 → Done and Fail=1 at cycle 100 of BUSY; state returns to IDLE.
- Write with Set_pointer: Req[1] write, Req_data[1]=8'h3C, Req_data2[1]=8'hC3, Set_pointer=1 → M_* fields equal those values and stay stable LATCH..DONE; Rd_data unchanged; Fail=0.
- Reset mid-BUSY: Rst=1 for 1 cycle → next cycle all outputs 0, no Done pulse, and requester 0 is granted first afterwards.
